// File: rtl/pll_startup_ctrl_if.sv
// -----------------------------------------------------------------------------
// pll_startup_ctrl_if
//   Bundles the bring-up sequencer's control and status signals toward the
//   PLL and its frequency counter. refclk and rst stay plain module ports.
//
//   en          enable sequencing (low returns the sequencer to IDLE)
//   meas_done   1-cycle pulse, meas_cnt valid
//   meas_cnt    frequency-counter result
//   pll_rstb    PLL reset, active-low
//   band        VCO coarse band code
//   meas_start  1-cycle pulse requesting one measurement
//   cal_done    band search finished
//   locked      PLL locked
//   err         sticky failure flag
//   state       FSM state encoding (debug)
//
//   master : the sequencer side
//   slave  : the PLL / frequency-counter / system side
// -----------------------------------------------------------------------------
interface pll_startup_ctrl_if #(
  parameter int BAND_W = 4,
  parameter int CNT_W  = 12
);
  logic              en;
  logic              meas_done;
  logic [CNT_W-1:0]  meas_cnt;
  logic              pll_rstb;
  logic [BAND_W-1:0] band;
  logic              meas_start;
  logic              cal_done;
  logic              locked;
  logic              err;
  logic [2:0]        state;

  modport master (
    input  en, meas_done, meas_cnt,
    output pll_rstb, band, meas_start, cal_done, locked, err, state
  );

  modport slave (
    output en, meas_done, meas_cnt,
    input  pll_rstb, band, meas_start, cal_done, locked, err, state
  );
endinterface

// File: rtl/pll_startup_ctrl.sv
// -----------------------------------------------------------------------------
// pll_startup_ctrl
//   Bring-up sequencer for the charge-pump PLL. Holds the PLL in reset,
//   binary-searches the VCO coarse band using an external frequency counter,
//   then monitors lock. Loss of lock triggers a recalibration; repeated lock
//   timeouts end in a sticky error state. All logic runs on posedge refclk.
//
//   refclk  in  reference clock
//   rst     in  synchronous reset, active-high
//   bus     master modport of pll_startup_ctrl_if (handshake + status)
// -----------------------------------------------------------------------------
module pll_startup_ctrl #(
  parameter int BAND_W     = 4,
  parameter int CNT_W      = 12,
  parameter int TARGET     = 1000,
  parameter int TOL        = 4,
  parameter int RST_CYC    = 16,
  parameter int SETTLE_CYC = 64,
  parameter int LOCK_N     = 4,
  parameter int LOSS_N     = 2,
  parameter int LOCK_TO    = 32,
  parameter int MAX_RETRY  = 3
) (
  input logic                 refclk,
  input logic                 rst,
  pll_startup_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRST  = 3'd1,
    S_CSET  = 3'd2,
    S_CMEAS = 3'd3,
    S_LWAIT = 3'd4,
    S_LOCK  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam int CYC_MAX  = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
  localparam int CYC_W    = $clog2(CYC_MAX + 1);
  localparam int BIT_W    = (BAND_W > 1) ? $clog2(BAND_W) : 1;
  localparam int RETRY_W  = $clog2(MAX_RETRY + 1);
  localparam int STREAK_W = $clog2(LOCK_N + 1);
  localparam int LOSS_W   = $clog2(LOSS_N + 1);
  localparam int MCNT_W   = $clog2(LOCK_TO + 1);

  localparam logic [CYC_W-1:0]    RST_LAST    = CYC_W'(RST_CYC - 1);
  localparam logic [CYC_W-1:0]    SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
  localparam logic [BAND_W-1:0]   BAND_INIT   = {1'b1, {(BAND_W-1){1'b0}}};
  localparam logic [BIT_W-1:0]    BIT_TOP     = BIT_W'(BAND_W - 1);
  localparam logic [RETRY_W-1:0]  RETRY_LIM   = RETRY_W'(MAX_RETRY);
  localparam logic [STREAK_W-1:0] LOCK_LIM    = STREAK_W'(LOCK_N);
  localparam logic [LOSS_W-1:0]   LOSS_LIM    = LOSS_W'(LOSS_N);
  localparam logic [MCNT_W-1:0]   MCNT_LIM    = MCNT_W'(LOCK_TO);
  localparam logic signed [CNT_W:0] TARGET_S  = (CNT_W+1)'(TARGET);
  localparam logic signed [CNT_W:0] TOL_S     = (CNT_W+1)'(TOL);

  state_t              state_q, state_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [BAND_W-1:0]   band_q, band_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [LOSS_W-1:0]   loss_q, loss_d;
  logic [MCNT_W-1:0]   mcnt_q, mcnt_d;
  logic                cal_done_q, cal_done_d;
  logic                meas_start_q, meas_start_d;
  logic                pll_rstb_q, locked_q, err_q;

  // One extra bit keeps the signed difference exact at both ends of the
  // counter range (0 and all-ones).
  logic signed [CNT_W:0] diff;
  logic                  in_range;
  logic                  at_or_below;
  logic [BIT_W-1:0]      bit_dn;
  logic [RETRY_W-1:0]    retry_inc;
  logic [STREAK_W-1:0]   streak_inc;
  logic [LOSS_W-1:0]     loss_inc;
  logic [MCNT_W-1:0]     mcnt_inc;

  assign diff        = $signed({1'b0, bus.meas_cnt}) - TARGET_S;
  assign in_range    = (diff >= -TOL_S) && (diff <= TOL_S);
  // An exact hit keeps the bit, so the search settles on the code whose
  // frequency matches TARGET rather than the one below it.
  assign at_or_below = diff[CNT_W] || (diff == '0);
  assign bit_dn      = bit_q - BIT_W'(1);
  assign retry_inc   = retry_q + RETRY_W'(1);
  assign streak_inc  = streak_q + STREAK_W'(1);
  assign loss_inc    = loss_q + LOSS_W'(1);
  assign mcnt_inc    = mcnt_q + MCNT_W'(1);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    cyc_d        = cyc_q;
    bit_d        = bit_q;
    band_d       = band_q;
    retry_d      = retry_q;
    streak_d     = streak_q;
    loss_d       = loss_q;
    mcnt_d       = mcnt_q;
    cal_done_d   = cal_done_q;
    meas_start_d = 1'b0;

    if (!bus.en) begin
      // Dropping enable wins over any concurrent meas_done.
      state_d    = S_IDLE;
      cyc_d      = '0;
      bit_d      = '0;
      band_d     = '0;
      retry_d    = '0;
      streak_d   = '0;
      loss_d     = '0;
      mcnt_d     = '0;
      cal_done_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_PRST;
          retry_d = '0;
          cyc_d   = '0;
        end

        S_PRST: begin
          if (cyc_q == RST_LAST) begin
            state_d = S_CSET;
            cyc_d   = '0;
            band_d  = BAND_INIT;
            bit_d   = BIT_TOP;
          end else begin
            cyc_d = cyc_q + CYC_W'(1);
          end
        end

        S_CSET: begin
          if (cyc_q == SETTLE_LAST) begin
            state_d      = S_CMEAS;
            cyc_d        = '0;
            meas_start_d = 1'b1;
          end else begin
            cyc_d = cyc_q + CYC_W'(1);
          end
        end

        S_CMEAS: begin
          if (bus.meas_done) begin
            if (!at_or_below) band_d[bit_q] = 1'b0;
            if (bit_q != '0) begin
              band_d[bit_dn] = 1'b1;
              bit_d          = bit_dn;
              state_d        = S_CSET;
              cyc_d          = '0;
            end else begin
              state_d      = S_LWAIT;
              cal_done_d   = 1'b1;
              meas_start_d = 1'b1;
              streak_d     = '0;
              mcnt_d       = '0;
            end
          end
        end

        S_LWAIT: begin
          if (bus.meas_done) begin
            mcnt_d   = mcnt_inc;
            streak_d = in_range ? streak_inc : '0;
            if (in_range && (streak_inc == LOCK_LIM)) begin
              state_d      = S_LOCK;
              loss_d       = '0;
              meas_start_d = 1'b1;
            end else if (mcnt_inc == MCNT_LIM) begin
              retry_d = retry_inc;
              if (retry_inc == RETRY_LIM) begin
                state_d = S_ERR;
              end else begin
                state_d    = S_PRST;
                cyc_d      = '0;
                cal_done_d = 1'b0;
              end
            end else begin
              meas_start_d = 1'b1;
            end
          end
        end

        S_LOCK: begin
          if (bus.meas_done) begin
            if (in_range) begin
              loss_d       = '0;
              meas_start_d = 1'b1;
            end else if (loss_inc == LOSS_LIM) begin
              // Loss of lock recalibrates without consuming a retry.
              state_d    = S_PRST;
              cyc_d      = '0;
              loss_d     = '0;
              cal_done_d = 1'b0;
            end else begin
              loss_d       = loss_inc;
              meas_start_d = 1'b1;
            end
          end
        end

        S_ERR: begin
          // Held until rst or en falls.
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so the PLL sees glitch-free
  // controls; pll_rstb is low only in IDLE and PRST, which also guarantees
  // meas_start never fires while the PLL is held in reset.
  always_ff @(posedge refclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      cyc_q        <= '0;
      bit_q        <= '0;
      band_q       <= '0;
      retry_q      <= '0;
      streak_q     <= '0;
      loss_q       <= '0;
      mcnt_q       <= '0;
      cal_done_q   <= 1'b0;
      meas_start_q <= 1'b0;
      pll_rstb_q   <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      bit_q        <= bit_d;
      band_q       <= band_d;
      retry_q      <= retry_d;
      streak_q     <= streak_d;
      loss_q       <= loss_d;
      mcnt_q       <= mcnt_d;
      cal_done_q   <= cal_done_d;
      meas_start_q <= meas_start_d;
      pll_rstb_q   <= (state_d != S_IDLE) && (state_d != S_PRST);
      locked_q     <= (state_d == S_LOCK);
      err_q        <= (state_d == S_ERR);
    end
  end

  assign bus.pll_rstb   = pll_rstb_q;
  assign bus.band       = band_q;
  assign bus.meas_start = meas_start_q;
  assign bus.cal_done   = cal_done_q;
  assign bus.locked     = locked_q;
  assign bus.err        = err_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_pll_startup_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_startup_ctrl
//   Directed bench for pll_startup_ctrl. A small frequency-counter model
//   answers each meas_start after a fixed latency with 900+25*band, a
//   constant, or an injected value. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pll_startup_ctrl;

  localparam int LAT = 3;

  logic refclk;
  logic rst;

  pll_startup_ctrl_if #(.BAND_W(4), .CNT_W(12)) ifc ();

  pll_startup_ctrl dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (ifc)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  int          n_checks = 0;
  int          n_err    = 0;
  int          pend     = 0;
  int          n_done   = 0;
  int          lw_meas  = 0;
  int          prst_entries = 0;
  int          err_starts   = 0;
  int          viol     = 0;
  int          mode     = 0;
  int          inject_left = 0;
  logic [11:0] const_cnt  = 12'd0;
  logic [11:0] inject_val = 12'd0;
  logic [2:0]  prev_state = 3'd0;
  logic [3:0]  band_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, then play the frequency counter.
  task automatic tick();
    @(negedge refclk);
    ifc.meas_done = 1'b0;
    if (ifc.meas_start && !ifc.pll_rstb) viol++;
    if (ifc.state == 3'd6 && ifc.meas_start) err_starts++;
    if (ifc.state == 3'd1 && prev_state != 3'd1) prst_entries++;
    prev_state = ifc.state;
    if (ifc.meas_start) begin
      if (ifc.state == 3'd3) band_log.push_back(ifc.band);
      pend = LAT;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        if (inject_left > 0) begin
          ifc.meas_cnt = inject_val;
          inject_left--;
        end else if (mode == 1) begin
          ifc.meas_cnt = const_cnt;
        end else begin
          ifc.meas_cnt = 12'(900 + 25 * int'(ifc.band));
        end
        if (ifc.state == 3'd4) lw_meas++;
        n_done++;
        ifc.meas_done = 1'b1;
      end
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int k;
    k = 0;
    while (ifc.state !== s && k < budget) begin
      tick();
      k++;
    end
    check(tag, ifc.state, s);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},      ifc.state, 0);
    check({tag, "_pll_rstb"},   ifc.pll_rstb, 0);
    check({tag, "_band"},       ifc.band, 0);
    check({tag, "_meas_start"}, ifc.meas_start, 0);
    check({tag, "_cal_done"},   ifc.cal_done, 0);
    check({tag, "_locked"},     ifc.locked, 0);
    check({tag, "_err"},        ifc.err, 0);
  endtask

  initial begin
    int k;
    int base;
    int drop;

    rst = 1'b1;
    ifc.en = 1'b0;
    ifc.meas_done = 1'b0;
    ifc.meas_cnt = 12'd0;
    tick();
    tick();
    check_reset_values("reset");

    // Bring-up: PRST length, settle time, binary search 8,4,6,5 -> 4.
    ifc.en = 1'b1;
    rst = 1'b0;
    wait_state(3'd1, 10, "enter_prst");
    k = 0;
    while (ifc.state == 3'd1 && ifc.pll_rstb == 1'b0 && k < 100) begin
      tick();
      k++;
    end
    check("prst_len", k, 16);
    check("cset_state", ifc.state, 2);
    check("rstb_high", ifc.pll_rstb, 1);
    check("band_init", ifc.band, 8);
    k = 0;
    while (!ifc.meas_start && k < 200) begin
      tick();
      k++;
    end
    check("settle_len", k, 64);
    wait_state(3'd4, 2000, "cal_end");
    check("band_log_size", band_log.size(), 4);
    if (band_log.size() == 4) begin
      check("band_seq0", band_log[0], 8);
      check("band_seq1", band_log[1], 4);
      check("band_seq2", band_log[2], 6);
      check("band_seq3", band_log[3], 5);
    end
    check("band_final", ifc.band, 4);
    check("cal_done_set", ifc.cal_done, 1);
    check("not_locked_yet", ifc.locked, 0);

    wait_state(3'd5, 500, "lock");
    check("lock_meas", lw_meas, 4);
    check("locked", ifc.locked, 1);
    check("cal_done_in_lock", ifc.cal_done, 1);

    // A single out-of-range sample must not drop lock.
    inject_val = 12'd1010;
    inject_left = 1;
    base = n_done;
    drop = 0;
    k = 0;
    while (n_done < base + 3 && k < 200) begin
      tick();
      k++;
      if (!ifc.locked) drop++;
    end
    tick();
    tick();
    if (!ifc.locked) drop++;
    check("single_oor_meas", n_done - base, 3);
    check("single_oor_drop", drop, 0);
    check("single_oor_state", ifc.state, 5);

    // Two consecutive out-of-range samples: loss of lock and recalibration.
    inject_left = 2;
    wait_state(3'd1, 200, "loss_prst");
    check("loss_locked", ifc.locked, 0);
    check("loss_cal_done", ifc.cal_done, 0);
    check("loss_rstb", ifc.pll_rstb, 0);
    k = 0;
    while (!ifc.pll_rstb && k < 100) begin
      tick();
      k++;
    end
    check("recal_rstb_pulse", k, 16);

    // Spurious meas_done while settling is ignored.
    check("spur_pre_state", ifc.state, 2);
    band_log.delete();
    ifc.meas_done = 1'b1;
    ifc.meas_cnt = 12'd0;
    tick();
    check("spur_state", ifc.state, 2);
    check("spur_band", ifc.band, 8);
    wait_state(3'd5, 3000, "relock");
    check("relock_band", ifc.band, 4);
    check("relock_cal_steps", band_log.size(), 4);

    // Permanent 1200: three lock windows of 32 measurements, then ERR.
    rst = 1'b1;
    pend = 0;
    inject_left = 0;
    ifc.meas_done = 1'b0;
    tick();
    tick();
    mode = 1;
    const_cnt = 12'd1200;
    prst_entries = 0;
    lw_meas = 0;
    err_starts = 0;
    rst = 1'b0;
    wait_state(3'd6, 5000, "err_state");
    check("err_flag", ifc.err, 1);
    check("err_prst_entries", prst_entries, 3);
    check("err_lwait_meas", lw_meas, 96);
    check("err_band", ifc.band, 0);
    check("err_rstb", ifc.pll_rstb, 1);
    check("err_locked", ifc.locked, 0);
    repeat (20) tick();
    check("err_no_meas", err_starts, 0);
    check("err_sticky", ifc.err, 1);
    ifc.en = 1'b0;
    pend = 0;
    tick();
    check("en_low_state", ifc.state, 0);
    check("en_low_err", ifc.err, 0);
    check("en_low_rstb", ifc.pll_rstb, 0);
    check("en_low_band", ifc.band, 0);

    // Counter extremes: 0 drives band to all-ones, 4095 to zero, no wrap.
    const_cnt = 12'd0;
    ifc.en = 1'b1;
    wait_state(3'd4, 2000, "ext0_lwait");
    check("ext0_band", ifc.band, 15);
    ifc.en = 1'b0;
    pend = 0;
    tick();
    const_cnt = 12'd4095;
    ifc.en = 1'b1;
    wait_state(3'd4, 2000, "ext4095_lwait");
    check("ext4095_band", ifc.band, 0);

    // Reset in the middle of a measurement aborts to reset values.
    ifc.en = 1'b0;
    pend = 0;
    tick();
    mode = 0;
    ifc.en = 1'b1;
    wait_state(3'd3, 200, "mid_cmeas");
    rst = 1'b1;
    pend = 0;
    tick();
    check_reset_values("mid_rst");
    rst = 1'b0;
    tick();

    check("start_while_rstb_low", viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
